pipe_ctrl_hazard: RTL and testbench

Consumer end of the decoded control bundle. Takes per-instruction control signals and register indices from the decode (ID) stage and carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers. Detects load-use hazards and generates stall/bubble, resolves taken branches into flush/pc_src, and produces ALU operand forwarding selects. Sits between the control decoder and the datapath stage registers of the 5-stage core.

---
 rtl/pipe_ctrl_hazard_pkg.sv | 33 +++
 rtl/pipe_ctrl_hazard_if.sv | 39 +++
 rtl/pipe_ctrl_hazard_fwd_unit.sv | 31 +++
 rtl/pipe_ctrl_hazard.sv | 112 +++++++++++
 tb/tb_pipe_ctrl_hazard.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_hazard_pkg.sv
// rtl/pipe_ctrl_hazard_pkg.sv - shared control bundle type, opcodes and forward-select codes
package pipe_ctrl_pkg;

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // The younger producer (EX/MEM) always shadows the older one (MEM/WB).
  function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
    if (mem_hit) begin
      return FWD_MEM;
    end else if (wb_hit) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_if.sv
// rtl/pipe_ctrl_hazard_if.sv - decode-side inputs and datapath-side control outputs of the hazard block
interface pipe_ctrl_hazard_if
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
);
  logic              id_valid;
  ctrl_t             id_ctrl;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              ex_zero;
  logic              hold;

  ctrl_t             ex_ctrl;
  ctrl_t             mem_ctrl;
  ctrl_t             wb_ctrl;
  logic [REG_AW-1:0] mem_rd;
  logic [REG_AW-1:0] wb_rd;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              pc_write;
  logic              ifid_write;
  logic              flush_ifid;
  logic              pc_src;

  modport master (
    output id_valid, id_ctrl, id_rs1, id_rs2, id_rd, ex_zero, hold,
    input  ex_ctrl, mem_ctrl, wb_ctrl, mem_rd, wb_rd, fwd_a, fwd_b,
    input  pc_write, ifid_write, flush_ifid, pc_src
  );

  modport slave (
    input  id_valid, id_ctrl, id_rs1, id_rs2, id_rd, ex_zero, hold,
    output ex_ctrl, mem_ctrl, wb_ctrl, mem_rd, wb_rd, fwd_a, fwd_b,
    output pc_write, ifid_write, flush_ifid, pc_src
  );

endinterface

// File: rtl/pipe_ctrl_hazard_fwd_unit.sv
// rtl/pipe_ctrl_hazard_fwd_unit.sv - combinational ALU operand forwarding select
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              i_mem_valid,
  input  logic              i_mem_regwrite,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_wb_valid,
  input  logic              i_wb_regwrite,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic [REG_AW-1:0] i_ex_rs1,
  input  logic [REG_AW-1:0] i_ex_rs2,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b
);

  logic w_mem_src;
  logic w_wb_src;

  // x0 is hardwired zero, so a write to it is never a forwarding source.
  assign w_mem_src = i_mem_valid & i_mem_regwrite & (i_mem_rd != '0);
  assign w_wb_src  = i_wb_valid & i_wb_regwrite & (i_wb_rd != '0);

  assign o_fwd_a = fwd_select(w_mem_src & (i_mem_rd == i_ex_rs1),
                              w_wb_src & (i_wb_rd == i_ex_rs1));
  assign o_fwd_b = fwd_select(w_mem_src & (i_mem_rd == i_ex_rs2),
                              w_wb_src & (i_wb_rd == i_ex_rs2));

endmodule

// File: rtl/pipe_ctrl_hazard.sv
// rtl/pipe_ctrl_hazard.sv - ID/EX, EX/MEM, MEM/WB control registers with load-use stall and branch flush
module pipe_ctrl_hazard
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_ctrl_hazard_if.slave  bus
);

  logic              r_ex_valid;
  ctrl_t             r_ex_ctrl;
  logic [REG_AW-1:0] r_ex_rs1;
  logic [REG_AW-1:0] r_ex_rs2;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_mem_valid;
  ctrl_t             r_mem_ctrl;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_wb_valid;
  ctrl_t             r_wb_ctrl;
  logic [REG_AW-1:0] r_wb_rd;

  logic              w_id_use_rs1;
  logic              w_id_use_rs2;
  logic              w_load_use;
  logic              w_taken;
  logic              w_ex_take_id;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;

  // Immediate-form instructions only read rs2 when it carries store data.
  assign w_id_use_rs1 = bus.id_valid;
  assign w_id_use_rs2 = bus.id_valid & (~bus.id_ctrl.alusrc | bus.id_ctrl.memwrite);

  assign w_load_use = r_ex_valid & r_ex_ctrl.memread & (r_ex_rd != '0) &
                      ((w_id_use_rs1 & (r_ex_rd == bus.id_rs1)) |
                       (w_id_use_rs2 & (r_ex_rd == bus.id_rs2)));

  assign w_taken      = r_ex_valid & r_ex_ctrl.branch & bus.ex_zero;
  assign w_ex_take_id = bus.id_valid & ~w_taken & ~w_load_use;

  always_comb begin
    bus.pc_write   = 1'b1;
    bus.ifid_write = 1'b1;
    bus.flush_ifid = 1'b0;
    bus.pc_src     = 1'b0;
    if (bus.hold) begin
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
    end else if (w_taken) begin
      bus.pc_src     = 1'b1;
      bus.flush_ifid = 1'b1;
    end else if (w_load_use) begin
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid  <= 1'b0;
      r_ex_ctrl   <= '0;
      r_ex_rs1    <= '0;
      r_ex_rs2    <= '0;
      r_ex_rd     <= '0;
      r_mem_valid <= 1'b0;
      r_mem_ctrl  <= '0;
      r_mem_rd    <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_ctrl   <= '0;
      r_wb_rd     <= '0;
    end else if (!bus.hold) begin
      // Wrong-path, stalled and empty slots all enter EX as an all-zero bubble.
      r_ex_valid  <= w_ex_take_id;
      r_ex_ctrl   <= w_ex_take_id ? bus.id_ctrl : '0;
      r_ex_rs1    <= w_ex_take_id ? bus.id_rs1 : '0;
      r_ex_rs2    <= w_ex_take_id ? bus.id_rs2 : '0;
      r_ex_rd     <= w_ex_take_id ? bus.id_rd : '0;
      r_mem_valid <= r_ex_valid;
      r_mem_ctrl  <= r_ex_ctrl;
      r_mem_rd    <= r_ex_rd;
      r_wb_valid  <= r_mem_valid;
      r_wb_ctrl   <= r_mem_ctrl;
      r_wb_rd     <= r_mem_rd;
    end
  end

  pipe_fwd_unit #(
    .REG_AW (REG_AW)
  ) u_fwd (
    .i_mem_valid    (r_mem_valid),
    .i_mem_regwrite (r_mem_ctrl.regwrite),
    .i_mem_rd       (r_mem_rd),
    .i_wb_valid     (r_wb_valid),
    .i_wb_regwrite  (r_wb_ctrl.regwrite),
    .i_wb_rd        (r_wb_rd),
    .i_ex_rs1       (r_ex_rs1),
    .i_ex_rs2       (r_ex_rs2),
    .o_fwd_a        (w_fwd_a),
    .o_fwd_b        (w_fwd_b)
  );

  assign bus.ex_ctrl  = r_ex_ctrl;
  assign bus.mem_ctrl = r_mem_ctrl;
  assign bus.wb_ctrl  = r_wb_ctrl;
  assign bus.mem_rd   = r_mem_rd;
  assign bus.wb_rd    = r_wb_rd;
  assign bus.fwd_a    = w_fwd_a;
  assign bus.fwd_b    = w_fwd_b;

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// tb/tb_pipe_ctrl_hazard.sv - directed bench with an instruction-level pipeline model for pipe_ctrl_hazard
module tb_pipe_ctrl_hazard;
  import pipe_ctrl_pkg::*;

  localparam logic [7:0] C_R   = 8'h22;
  localparam logic [7:0] C_LW  = 8'hF0;
  localparam logic [7:0] C_SW  = 8'h88;
  localparam logic [7:0] C_BEQ = 8'h05;
  localparam logic [7:0] C_IMM = 8'hA0;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipe_ctrl_hazard_if #(.REG_AW(5)) bus ();

  pipe_ctrl_hazard #(.REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       v;
    logic [7:0] c;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } inst_t;

  inst_t m_pipe [0:2];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit writes_reg(input inst_t s);
    return s.v && s.c[5] && (s.rd != 5'd0);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (writes_reg(m_pipe[1]) && m_pipe[1].rd == src) return 2'b10;
    if (writes_reg(m_pipe[2]) && m_pipe[2].rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_taken();
    return m_pipe[0].v && m_pipe[0].c[2] && bus.ex_zero;
  endfunction

  function automatic bit m_stall();
    bit reads1, reads2, load_ex;
    reads1  = bus.id_valid;
    reads2  = bus.id_valid && (!bus.id_ctrl[7] || bus.id_ctrl[3]);
    load_ex = m_pipe[0].v && m_pipe[0].c[4] && (m_pipe[0].rd != 5'd0);
    return load_ex && ((reads1 && m_pipe[0].rd == bus.id_rs1) ||
                       (reads2 && m_pipe[0].rd == bus.id_rs2));
  endfunction

  function automatic logic e_advance();
    return !bus.hold && (m_taken() || !m_stall());
  endfunction

  function automatic logic e_redirect();
    return !bus.hold && m_taken();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m_pipe[i] <= '0;
    end else if (!bus.hold) begin
      m_pipe[2] <= m_pipe[1];
      m_pipe[1] <= m_pipe[0];
      m_pipe[0] <= (bus.id_valid && !m_taken() && !m_stall()) ?
                   {1'b1, bus.id_ctrl, bus.id_rs1, bus.id_rs2, bus.id_rd} : '0;
    end
  end

  always @(negedge clk) begin
    check("m_pc_write",   {7'd0, bus.pc_write},   {7'd0, e_advance()});
    check("m_ifid_write", {7'd0, bus.ifid_write}, {7'd0, e_advance()});
    check("m_flush_ifid", {7'd0, bus.flush_ifid}, {7'd0, e_redirect()});
    check("m_pc_src",     {7'd0, bus.pc_src},     {7'd0, e_redirect()});
    check("m_ex_ctrl",    bus.ex_ctrl,            m_pipe[0].c);
    check("m_mem_ctrl",   bus.mem_ctrl,           m_pipe[1].c);
    check("m_wb_ctrl",    bus.wb_ctrl,            m_pipe[2].c);
    check("m_mem_rd",     {3'd0, bus.mem_rd},     {3'd0, m_pipe[1].rd});
    check("m_wb_rd",      {3'd0, bus.wb_rd},      {3'd0, m_pipe[2].rd});
    check("m_fwd_a",      {6'd0, bus.fwd_a},      {6'd0, m_fwd(m_pipe[0].rs1)});
    check("m_fwd_b",      {6'd0, bus.fwd_b},      {6'd0, m_fwd(m_pipe[0].rs2)});
  end

  task automatic drive(input logic v, input logic [7:0] c,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    bus.id_valid = v;
    bus.id_ctrl  = c;
    bus.id_rs1   = rs1;
    bus.id_rs2   = rs2;
    bus.id_rd    = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.hold    = 1'b0;
    bus.ex_zero = 1'b0;
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // idle after reset
    for (int i = 0; i < 5; i++) begin
      #2;
      check("idle_pc_write", {7'd0, bus.pc_write}, 8'h01);
      check("idle_ifid_write", {7'd0, bus.ifid_write}, 8'h01);
      check("idle_ex_ctrl", bus.ex_ctrl, 8'h00);
      check("idle_mem_ctrl", bus.mem_ctrl, 8'h00);
      check("idle_wb_ctrl", bus.wb_ctrl, 8'h00);
      tick();
    end

    // back-to-back ALU dependency, then with one nop between
    drive(1'b1, C_R, 5'd1, 5'd2, 5'd3); tick();
    drive(1'b1, C_R, 5'd3, 5'd1, 5'd4); tick();
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0); #2;
    check("b2b_fwd_a", {6'd0, bus.fwd_a}, 8'h02);
    check("b2b_fwd_b", {6'd0, bus.fwd_b}, 8'h00);
    check("b2b_mem_rd", {3'd0, bus.mem_rd}, 8'h03);
    tick();
    drive(1'b1, C_R, 5'd1, 5'd2, 5'd3); tick();
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0); tick();
    drive(1'b1, C_R, 5'd3, 5'd1, 5'd4); tick();
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0); #2;
    check("gap_fwd_a", {6'd0, bus.fwd_a}, 8'h01);
    check("gap_wb_rd", {3'd0, bus.wb_rd}, 8'h03);
    tick();

    // load-use: lw x5 then add x6,x5,x1
    drive(1'b1, C_LW, 5'd1, 5'd0, 5'd5); tick();
    drive(1'b1, C_R, 5'd5, 5'd1, 5'd6); #2;
    check("lu_pc_write", {7'd0, bus.pc_write}, 8'h00);
    check("lu_ifid_write", {7'd0, bus.ifid_write}, 8'h00);
    tick(); #2;
    check("lu_bubble", bus.ex_ctrl, 8'h00);
    check("lu_mem_ctrl", bus.mem_ctrl, 8'hF0);
    check("lu_resume", {7'd0, bus.pc_write}, 8'h01);
    tick();
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0); #2;
    check("lu_ex_ctrl", bus.ex_ctrl, 8'h22);
    check("lu_fwd_a", {6'd0, bus.fwd_a}, 8'h01);
    tick();

    // taken and not-taken branch
    drive(1'b1, C_BEQ, 5'd1, 5'd2, 5'd0); tick();
    drive(1'b1, C_R, 5'd1, 5'd2, 5'd7); bus.ex_zero = 1'b1; #2;
    check("tk_pc_src", {7'd0, bus.pc_src}, 8'h01);
    check("tk_flush", {7'd0, bus.flush_ifid}, 8'h01);
    tick();
    bus.ex_zero = 1'b0;
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0); #2;
    check("tk_bubble", bus.ex_ctrl, 8'h00);
    check("tk_one_cycle", {7'd0, bus.flush_ifid}, 8'h00);
    tick();
    drive(1'b1, C_BEQ, 5'd1, 5'd2, 5'd0); tick();
    drive(1'b1, C_R, 5'd1, 5'd2, 5'd7); #2;
    check("nt_pc_src", {7'd0, bus.pc_src}, 8'h00);
    tick();
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0); #2;
    check("nt_ex_ctrl", bus.ex_ctrl, 8'h22);
    tick();

    // taken branch with lw x5 in MEM and a reader of x5 in ID
    drive(1'b1, C_LW, 5'd1, 5'd0, 5'd5); tick();
    drive(1'b1, C_BEQ, 5'd1, 5'd2, 5'd0); tick();
    drive(1'b1, C_R, 5'd5, 5'd1, 5'd7); bus.ex_zero = 1'b1; #2;
    check("tklu_pc_write", {7'd0, bus.pc_write}, 8'h01);
    check("tklu_pc_src", {7'd0, bus.pc_src}, 8'h01);
    check("tklu_mem_ctrl", bus.mem_ctrl, 8'hF0);
    tick();
    bus.ex_zero = 1'b0;
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0); tick();

    // hold with lw in EX and dependent add in ID
    drive(1'b1, C_LW, 5'd1, 5'd0, 5'd5); tick();
    drive(1'b1, C_R, 5'd5, 5'd1, 5'd6); bus.hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("hold_pc_write", {7'd0, bus.pc_write}, 8'h00);
      check("hold_ex_ctrl", bus.ex_ctrl, 8'hF0);
      check("hold_mem_ctrl", bus.mem_ctrl, 8'h00);
      tick();
    end
    bus.hold = 1'b0; #2;
    check("hold_stall", {7'd0, bus.pc_write}, 8'h00);
    tick(); #2;
    check("hold_one_stall", {7'd0, bus.pc_write}, 8'h01);
    check("hold_mem_lw", bus.mem_ctrl, 8'hF0);
    tick();
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0); #2;
    check("hold_fwd_a", {6'd0, bus.fwd_a}, 8'h01);
    tick();

    // taken branch under hold waits for release
    drive(1'b1, C_BEQ, 5'd1, 5'd2, 5'd0); tick();
    drive(1'b1, C_R, 5'd1, 5'd2, 5'd7); bus.ex_zero = 1'b1; bus.hold = 1'b1; #2;
    check("htk_pc_src", {7'd0, bus.pc_src}, 8'h00);
    tick();
    bus.hold = 1'b0; #2;
    check("htk_release", {7'd0, bus.pc_src}, 8'h01);
    tick();
    bus.ex_zero = 1'b0;
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0); tick();

    // x0 never forwards nor stalls
    drive(1'b1, C_R, 5'd1, 5'd2, 5'd0); tick();
    drive(1'b1, C_R, 5'd0, 5'd0, 5'd8); tick();
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0); #2;
    check("x0_fwd_a", {6'd0, bus.fwd_a}, 8'h00);
    check("x0_fwd_b", {6'd0, bus.fwd_b}, 8'h00);
    tick();
    drive(1'b1, C_LW, 5'd1, 5'd0, 5'd0); tick();
    drive(1'b1, C_R, 5'd0, 5'd0, 5'd9); #2;
    check("x0_no_stall", {7'd0, bus.pc_write}, 8'h01);
    tick();
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0); tick();

    // store data operand counts as a read, immediate-form rs2 field does not
    drive(1'b1, C_LW, 5'd1, 5'd0, 5'd5); tick();
    drive(1'b1, C_SW, 5'd1, 5'd5, 5'd0); #2;
    check("sw_rs2_stall", {7'd0, bus.pc_write}, 8'h00);
    tick();
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0); tick();
    drive(1'b1, C_LW, 5'd1, 5'd0, 5'd5); tick();
    drive(1'b1, C_IMM, 5'd1, 5'd5, 5'd9); #2;
    check("imm_no_stall", {7'd0, bus.pc_write}, 8'h01);
    tick();
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0); tick();

    // reset in the middle of a load-use stall
    drive(1'b1, C_LW, 5'd1, 5'd0, 5'd5); tick();
    drive(1'b1, C_R, 5'd5, 5'd1, 5'd6); #2;
    check("rst_pre_stall", {7'd0, bus.pc_write}, 8'h00);
    rst_n = 1'b0; #1;
    check("rst_pc_write", {7'd0, bus.pc_write}, 8'h01);
    check("rst_ex_ctrl", bus.ex_ctrl, 8'h00);
    check("rst_mem_ctrl", bus.mem_ctrl, 8'h00);
    check("rst_wb_ctrl", bus.wb_ctrl, 8'h00);
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
    tick(); tick();
    rst_n = 1'b1; #2;
    check("rst_after", {7'd0, bus.ifid_write}, 8'h01);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
